// File: rtl/pipelined_shifter.sv
// pipelined_shifter: WIDTH-bit left/right shift or rotate with zero, one or edge fill, plus carry, zero flag and tag.
// Latency: an op accepted at edge T is sampled with out_valid at edge T+LOG2W+1 (input register, then LOG2W barrel stages).
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready is that enable.
module pipelined_shifter #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] in_by,
  input  logic             in_dir,
  input  logic [1:0]       in_extend,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);

  // One in-flight operation: working value, running carry and the controls it still needs.
  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             carry;
    logic             dir;
    logic             rot;
    logic             fill;
    logic             sat;
    logic [LOG2W-1:0] amt;
    logic [TAG_W-1:0] tag;
  } slot_t;

  logic [LOG2W:0] vld;
  slot_t          pipe      [LOG2W+1];
  slot_t          stage_nxt [LOG2W];
  slot_t          in_slot;
  logic           en;
  logic           zero_q;

  assign out_valid  = vld[LOG2W];
  assign en         = !out_valid || out_ready;
  assign in_ready   = en;
  assign out_result = pipe[LOG2W].val;
  assign out_carry  = pipe[LOG2W].carry;
  assign out_tag    = pipe[LOG2W].tag;
  assign out_zero   = zero_q;

  // Decode the offered operation: fill bit, rotate flag, and saturation for out-of-range amounts
  always_comb begin
    in_slot     = '0;
    in_slot.val = in_value;
    in_slot.dir = in_dir;
    in_slot.rot = (in_extend == 2'd3);
    in_slot.amt = in_by[LOG2W-1:0];
    in_slot.tag = in_tag;
    // Rotate ignores the high amount bits; the other modes saturate on them.
    in_slot.sat = (in_extend != 2'd3) && (|in_by[WIDTH-1:LOG2W]);
    case (in_extend)
      2'd1:    in_slot.fill = 1'b1;
      2'd2:    in_slot.fill = in_dir ? in_value[WIDTH-1] : in_value[0];
      default: in_slot.fill = 1'b0;
    endcase
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    localparam int S = 1 << k;
    slot_t cur;
    slot_t nxt;
    assign cur = pipe[k];

    // Barrel level k: move by 2^k when amount bit k is set; the carry rides as an extra bit
    always_comb begin
      nxt = cur;
      if (cur.amt[k]) begin
        if (cur.rot) begin
          if (cur.dir) begin
            nxt.val   = {cur.val[S-1:0], cur.val[WIDTH-1:S]};
            nxt.carry = cur.val[S-1];
          end else begin
            nxt.val   = {cur.val[WIDTH-1-S:0], cur.val[WIDTH-1:WIDTH-S]};
            nxt.carry = cur.val[WIDTH-S];
          end
        end else if (cur.dir) begin
          {nxt.val, nxt.carry} = {{S{cur.fill}}, cur.val[WIDTH-1:S-1]};
        end else begin
          {nxt.carry, nxt.val} = {cur.val[WIDTH-S:0], {S{cur.fill}}};
        end
      end
      // Saturated ops are all fill regardless of the low amount bits; idempotent at every level.
      if (cur.sat) begin
        nxt.val   = {WIDTH{cur.fill}};
        nxt.carry = cur.fill;
      end
    end

    assign stage_nxt[k] = nxt;
  end

  // Advance all slots together under the global enable; reset flushes valids and clears outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      zero_q <= 1'b0;
      for (int i = 0; i <= LOG2W; i++) begin
        pipe[i] <= '0;
      end
    end else if (en) begin
      vld     <= {vld[LOG2W-1:0], in_valid};
      pipe[0] <= in_slot;
      for (int i = 0; i < LOG2W; i++) begin
        pipe[i+1] <= stage_nxt[i];
      end
      zero_q <= (stage_nxt[LOG2W-1].val == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboarded bench for pipelined_shifter at WIDTH=16.
// Driver pushes expected responses on accept; a negedge monitor compares against the queue head.
// Covers directed cases, stall window, mid-stream reset and randomized traffic with random out_ready.
module tb_pipelined_shifter;
  localparam int W   = 16;
  localparam int TW  = 4;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_value;
  logic [W-1:0]  in_by;
  logic          in_dir;
  logic [1:0]    in_extend;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_by(in_by),
    .in_dir(in_dir), .in_extend(in_extend), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          carry;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat_chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   rdy_mode    = 0;
  int   stall_lo    = -1;
  int   stall_hi    = -1;
  bit   lat_chk_now = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: each result bit taken directly from the operand position it comes from
  function automatic exp_t model(input logic [W-1:0] v, input logic [W-1:0] by,
                                 input logic dir, input logic [1:0] ext, input logic [TW-1:0] tag);
    exp_t e;
    int n;
    logic fill;
    logic [W-1:0] r;
    logic c;
    fill = (ext == 2'd1) ? 1'b1 : (ext == 2'd2) ? (dir ? v[W-1] : v[0]) : 1'b0;
    r = '0;
    c = 1'b0;
    if (ext == 2'd3) begin
      n = int'(by % W);
      for (int i = 0; i < W; i++) r[i] = dir ? v[(i + n) % W] : v[(i - n + W) % W];
      if (n != 0) c = dir ? r[W-1] : r[0];
    end else if (by >= W) begin
      r = {W{fill}};
      c = fill;
    end else begin
      n = int'(by);
      for (int i = 0; i < W; i++) begin
        if (dir) r[i] = (i + n < W) ? v[i + n] : fill;
        else     r[i] = (i >= n) ? v[i - n] : fill;
      end
      if (n != 0) c = dir ? v[n - 1] : v[W - n];
    end
    e.res = r; e.carry = c; e.zero = (r == '0); e.tag = tag; e.acc = 0; e.lat_chk = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] res, input logic carry, input logic [TW-1:0] tag);
    exp_t e;
    e.res = res; e.carry = carry; e.zero = (res == '0); e.tag = tag; e.acc = 0; e.lat_chk = 1'b0;
    return e;
  endfunction

  // Offer one op and push its expected response on the cycle it is accepted
  task automatic issue(input logic [W-1:0] v, input logic [W-1:0] by, input logic dir,
                       input logic [1:0] ext, input logic [TW-1:0] tag, input exp_t e_in);
    exp_t e;
    int waited;
    e = e_in;
    waited = 0;
    in_valid = 1'b1; in_value = v; in_by = by; in_dir = dir; in_extend = ext; in_tag = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc;
        e.lat_chk = lat_chk_now;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 100) begin
        chk("issue_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [TW-1:0] tag);
    logic [W-1:0] v, by;
    logic dir;
    logic [1:0] ext;
    v = W'($urandom);
    case ($urandom_range(0, 3))
      0, 1:    by = W'($urandom_range(0, 15));
      2:       by = W'($urandom_range(0, 31));
      default: by = W'($urandom);
    endcase
    dir = 1'($urandom);
    ext = 2'($urandom);
    issue(v, by, dir, ext, tag, model(v, by, dir, ext, tag));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  // out_ready pattern: always high, a fixed stall window, or random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: head of the scoreboard must be presented, and held while stalled
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sb[0];
          chk("result", out_result, mon_e.res);
          chk("carry", out_carry, mon_e.carry);
          chk("zero", out_zero, mon_e.zero);
          chk("tag", out_tag, mon_e.tag);
          if (out_ready) begin
            void'(sb.pop_front());
            if (mon_e.lat_chk) chk("latency", cyc - mon_e.acc, LAT);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset with an op offered throughout; it must not be accepted.
    reset = 1'b1; in_valid = 1'b1; in_value = 16'hBEEF; in_by = 16'd3;
    in_dir = 1'b0; in_extend = 2'd0; in_tag = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_carry", out_carry, 32'd0);
    chk("rst_zero", out_zero, 32'd0);
    chk("rst_tag", out_tag, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    idle(7);

    // Directed cases with hand-derived expectations, back to back at full rate.
    lat_chk_now = 1'b1;
    issue(16'h8001, 16'd1,     1'b0, 2'd0, 4'd1,  mk(16'h0002, 1'b1, 4'd1));
    issue(16'h8000, 16'd4,     1'b1, 2'd2, 4'd2,  mk(16'hF800, 1'b0, 4'd2));
    issue(16'h800F, 16'd4,     1'b1, 2'd2, 4'd3,  mk(16'hF800, 1'b1, 4'd3));
    issue(16'h1234, 16'd20,    1'b1, 2'd3, 4'd4,  mk(16'h4123, 1'b0, 4'd4));
    issue(16'h1234, 16'd4,     1'b0, 2'd3, 4'd5,  mk(16'h2341, 1'b1, 4'd5));
    issue(16'h1234, 16'd0,     1'b0, 2'd3, 4'd6,  mk(16'h1234, 1'b0, 4'd6));
    issue(16'h00FF, 16'h0100,  1'b0, 2'd1, 4'd7,  mk(16'hFFFF, 1'b1, 4'd7));
    issue(16'h00FF, 16'h0100,  1'b1, 2'd0, 4'd8,  mk(16'h0000, 1'b0, 4'd8));
    issue(16'hA5A5, 16'd15,    1'b0, 2'd0, 4'd9,  mk(16'h8000, 1'b0, 4'd9));
    issue(16'hA5A5, 16'd16,    1'b1, 2'd2, 4'd10, mk(16'hFFFF, 1'b1, 4'd10));
    issue(16'h0000, 16'd3,     1'b0, 2'd1, 4'd11, mk(16'h0007, 1'b0, 4'd11));
    issue(16'h1234, 16'd16,    1'b1, 2'd3, 4'd12, mk(16'h1234, 1'b0, 4'd12));
    issue(16'h0001, 16'hFFF1,  1'b1, 2'd3, 4'd13, mk(16'h8000, 1'b1, 4'd13));
    drain();

    // Backpressure: 8 back-to-back ops, out_ready low for relative cycles 6..9.
    lat_chk_now = 1'b0;
    base = cyc;
    stall_lo = base + 6;
    stall_hi = base + 9;
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) issue_rand(TW'(t));
    drain();
    rdy_mode = 0;
    idle(2);

    // Reset with three ops in flight; none may emerge and a fresh op must see full latency.
    lat_chk_now = 1'b1;
    for (int t = 0; t < 3; t++) issue_rand(TW'(t + 4));
    reset = 1'b1;
    in_valid = 1'b1; in_value = 16'h0F0F; in_by = 16'd1; in_tag = 4'h9;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_tag", out_tag, 32'd0);
    @(posedge clk); #1;
    idle(7);
    issue(16'h4001, 16'd2, 1'b1, 2'd2, 4'd14, mk(16'h1000, 1'b0, 4'd14));
    drain();

    // Randomized traffic with random gaps and random out_ready.
    lat_chk_now = 1'b0;
    rdy_mode = 2;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue_rand(TW'(t));
    end
    drain();
    rdy_mode = 0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
